wb_scoreboard: RTL and testbench
================================

WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 Parameter: ADDR_W, 3, register-address width; register count is 2**ADDR_W.
REQ-002 Parameter: DEPTH, 3, pipeline stages from issue to writeback (legal range 2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 issue_valid  input  1  instruction presented for issue this cycle.
REQ-006 opcode  input  5  opcode of the presented instruction.
REQ-007 rd  input  ADDR_W  destination register of the presented instruction.
REQ-008 rs, rt  input  ADDR_W each  source registers of the presented instruction.
REQ-009 rs_used, rt_used  input  1 each  source register actually read.
REQ-010 flush  input  1  squash all uncommitted in-flight entries.
REQ-011 reg_write  output  1  combinational decode: presented opcode writes a register.
REQ-012 stall  output  1  presented instruction must not issue this cycle.
REQ-013 pending  output  2**ADDR_W  bit r set when any tracked stage holds a valid write to r.
REQ-014 wb_valid, wb_addr  output  1, ADDR_W  write retiring from the final stage this cycle.

Function
REQ-015 reg_write SHALL be 1 exactly for opcodes 01000-01011, 10100-10111, 10001, 10011, 10010, 11000, 11001, 11010, 11011, 11100-11111, 00110, 00111; 0 otherwise.
REQ-016 Block SHALL hold DEPTH entries stage[0..DEPTH-1], each {valid, addr}.
REQ-017 hit(x) SHALL be 1 when any entry in the hazard window is valid with addr == x; no register is exempt (R0 is ordinary).
REQ-018 stall SHALL equal issue_valid & ((rs_used & hit(rs)) | (rt_used & hit(rt))); it is combinational, zero-cycle latency.
REQ-019 fire SHALL equal issue_valid & ~stall & ~flush.
REQ-020 Each rising edge, stage[i+1] SHALL take stage[i] for i = 0..DEPTH-2, unconditionally (stall inserts a bubble, never freezes the shift).
REQ-021 stage[0] SHALL take {fire & reg_write, rd}; a stalled or non-writing instruction enters as a bubble (valid 0).
REQ-022 On an edge with flush=1, stage[0..DEPTH-2] SHALL load valid 0 and stage[DEPTH-1] SHALL still take stage[DEPTH-2] (that entry is past commit).
REQ-023 flush SHALL take priority over issue_valid in the same cycle; no issue occurs.
REQ-024 wb_valid/wb_addr SHALL reflect stage[DEPTH-1] directly (registered, no combinational path from inputs).
REQ-025 pending SHALL be the OR over all DEPTH stages of one-hot(addr) & valid, independent of bypass configuration.
REQ-026 Two in-flight writes to the same register SHALL both be tracked; the register stays pending until the younger retires.
REQ-027 Instruction with rd equal to its own rs SHALL not self-stall (hazard check uses stages only, not the presented entry).

Reset
REQ-028 While rst=1, all stage valid bits SHALL be 0 immediately, independent of clk; pending=0, wb_valid=0, wb_addr=0.
REQ-029 rst asserted mid-stream SHALL discard all in-flight entries; first edge after release behaves as from empty.
REQ-030 reg_write and stall SHALL remain pure functions of current inputs and state during reset (stall=0, since no entry is valid).

Configuration
REQ-031 Macro WB_BYPASS_EN SHALL select the hazard window.
REQ-032 With WB_BYPASS_EN defined, hazard window SHALL be stage[0..DEPTH-2]; a match only in stage[DEPTH-1] does not stall (register file writes before read).
REQ-033 Without WB_BYPASS_EN, hazard window SHALL be stage[0..DEPTH-1].

Verification (DEPTH=3, ADDR_W=3)
REQ-034 Issue ADDI (01000) rd=5, next cycle issue rs=5 rs_used=1 -> stall=1 for 2 cycles with WB_BYPASS_EN, 3 without; wb_valid=1, wb_addr=5 on third edge after issue.
REQ-035 Issue ST-type opcode 10000 rd=5, next rs=5 -> reg_write=0, stall=0, pending stays 0.
REQ-036 Issue writes to r2 then r3 back-to-back, third instruction rt=3 rt_used=0, rs=4 -> stall=0; pending=8'b00001100 after second edge.
REQ-037 Issue rd=6, rd=6 on consecutive cycles, flush on the next edge -> only first entry retires (wb_valid pulses once, addr=6); pending=0 one edge later.
REQ-038 Fill all stages, assert rst between edges -> pending=0 and wb_valid=0 immediately; after release, rs=any -> stall=0.
REQ-039 Sweep all 32 opcodes with issue_valid=1 -> reg_write matches REQ-015 table exactly (21 ones).

Source files
------------

// File: rtl/wb_scoreboard_if.sv
// ---------------------------------------------------------------------------
// wb_scoreboard_if
//   Issue/writeback bundle for the register write-back scoreboard.
//
//   Issue side (master drives):
//     issue_valid  instruction presented this cycle
//     opcode[4:0]  opcode of presented instruction
//     rd, rs, rt   destination / source register numbers (ADDR_W bits)
//     rs_used      rs is actually read
//     rt_used      rt is actually read
//     flush        squash all uncommitted in-flight entries
//   Scoreboard side (slave drives):
//     reg_write    presented opcode writes a register (combinational)
//     stall        presented instruction must not issue (combinational)
//     pending      bit r set while a tracked write to r is in flight
//     wb_valid     a write retires from the final stage this cycle
//     wb_addr      register written by the retiring entry
// ---------------------------------------------------------------------------
interface wb_scoreboard_if #(
  parameter int ADDR_W = 3
) ();
  logic                   issue_valid;
  logic [4:0]             opcode;
  logic [ADDR_W-1:0]      rd;
  logic [ADDR_W-1:0]      rs;
  logic [ADDR_W-1:0]      rt;
  logic                   rs_used;
  logic                   rt_used;
  logic                   flush;
  logic                   reg_write;
  logic                   stall;
  logic [2**ADDR_W-1:0]   pending;
  logic                   wb_valid;
  logic [ADDR_W-1:0]      wb_addr;

  modport master (
    output issue_valid, opcode, rd, rs, rt, rs_used, rt_used, flush,
    input  reg_write, stall, pending, wb_valid, wb_addr
  );

  modport slave (
    input  issue_valid, opcode, rd, rs, rt, rs_used, rt_used, flush,
    output reg_write, stall, pending, wb_valid, wb_addr
  );
endinterface

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
//   Tracks register writes in flight through a DEPTH-stage pipeline and
//   stalls issue of any instruction that reads a register still pending.
//
//   Ports:
//     clk   single clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   wb_scoreboard_if.slave (issue inputs, hazard/writeback outputs)
//
//   Parameters:
//     ADDR_W  register-address width (2**ADDR_W registers)
//     DEPTH   stages from issue to writeback, 2..8
//
//   Configuration macro:
//     WB_BYPASS_EN  defined   -> the final stage is excluded from the hazard
//                                window (register file writes before read).
//                   undefined -> all DEPTH stages are checked.
// ---------------------------------------------------------------------------
module wb_scoreboard #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 3
) (
  input logic             clk,
  input logic             rst,
  wb_scoreboard_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } entry_t;

`ifdef WB_BYPASS_EN
  localparam int WINDOW = DEPTH - 1;
`else
  localparam int WINDOW = DEPTH;
`endif

  entry_t stage_q [DEPTH];

  logic   reg_write;
  logic   hit_rs;
  logic   hit_rt;
  logic   stall;
  logic   fire;

  // Opcode decode: which opcodes write a destination register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    reg_write = 1'b0;
    case (bus.opcode)
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111,
      5'b10001, 5'b10010, 5'b10011,
      5'b11000, 5'b11001, 5'b11010, 5'b11011,
      5'b11100, 5'b11101, 5'b11110, 5'b11111,
      5'b00110, 5'b00111:  reg_write = 1'b1;
      default:             reg_write = 1'b0;
    endcase
  end

  // Hazard lookup over the stage window only; the presented instruction's
  // own rd is never compared, so rd == rs cannot self-stall.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 0; i < WINDOW; i++) begin
      if (stage_q[i].valid && stage_q[i].addr == bus.rs) hit_rs = 1'b1;
      if (stage_q[i].valid && stage_q[i].addr == bus.rt) hit_rt = 1'b1;
    end
  end

  assign stall = bus.issue_valid &
                 ((bus.rs_used & hit_rs) | (bus.rt_used & hit_rt));
  assign fire  = bus.issue_valid & ~stall & ~bus.flush;

  // Pipeline of write tags. The shift never freezes: a stalled or
  // non-writing instruction simply enters stage 0 as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every stage samples the pre-edge value of its predecessor.
    if (rst) begin
      // NOTE: the stage array is small and its valid bits must clear
      // asynchronously, so every entry is reset rather than left as memory.
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{valid: fire & reg_write, addr: bus.rd};
      for (int i = 1; i < DEPTH; i++) begin
        // The last stage is past commit, so flush never squashes it.
        if (bus.flush && i < DEPTH - 1) stage_q[i] <= '0;
        else                            stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Pending map covers every stage regardless of the hazard window.
  always_comb begin
    bus.pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (stage_q[i].valid) bus.pending[stage_q[i].addr] = 1'b1;
    end
  end

  assign bus.reg_write = reg_write;
  assign bus.stall     = stall;
  assign bus.wb_valid  = stage_q[DEPTH-1].valid;
  assign bus.wb_addr   = stage_q[DEPTH-1].addr;

endmodule

// File: tb/tb_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_wb_scoreboard
//   Directed bench for wb_scoreboard with DEPTH=3, ADDR_W=3. Inputs change
//   1 time unit after each rising edge; outputs are sampled 1 unit later.
//   Expectations follow WB_BYPASS_EN when the macro is defined for the build.
// ---------------------------------------------------------------------------
module tb_wb_scoreboard;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_scoreboard_if #(.ADDR_W(ADDR_W)) bus ();

  wb_scoreboard #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Advance to 1 unit past the next rising edge.
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 1'b0;
    bus.opcode      = 5'b00000;
    bus.rd          = '0;
    bus.rs          = '0;
    bus.rt          = '0;
    bus.rs_used     = 1'b0;
    bus.rt_used     = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic present(input logic [4:0] op, input logic [2:0] rd_i,
                         input logic [2:0] rs_i, input logic rs_u,
                         input logic [2:0] rt_i, input logic rt_u);
    bus.issue_valid = 1'b1;
    bus.opcode      = op;
    bus.rd          = rd_i;
    bus.rs          = rs_i;
    bus.rs_used     = rs_u;
    bus.rt          = rt_i;
    bus.rt_used     = rt_u;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (DEPTH + 1) next_edge();
  endtask

  task automatic test_reset();
    idle_inputs();
    #1;
    checks++;
    if (bus.pending !== 8'h00 || bus.wb_valid !== 1'b0 || bus.wb_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: pending=%b wb_valid=%b wb_addr=%0d, required 0/0/0",
               bus.pending, bus.wb_valid, bus.wb_addr);
    end
    next_edge();
    rst = 1'b0;
    next_edge();
  endtask

  // ADDI rd=5, then a dependent reader of r5.
  task automatic test_raw_stall();
    present(5'b01000, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0);
    #1;
    checks++;
    if (bus.reg_write !== 1'b1 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_issue: reg_write=%b stall=%b, required 1/0", bus.reg_write, bus.stall);
    end
    next_edge();  // edge 1 after issue presented
    present(5'b00000, 3'd0, 3'd5, 1'b1, 3'd0, 1'b0);
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.pending !== 8'b0010_0000) begin
      errors++;
      $display("FAIL raw_stall_c1: stall=%b pending=%b, required 1/00100000", bus.stall, bus.pending);
    end
    next_edge();
    checks++;
    if (bus.stall !== 1'b1 || bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_stall_c2: stall=%b wb_valid=%b, required 1/0", bus.stall, bus.wb_valid);
    end
    next_edge();  // entry now in final stage
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 3'd5 || bus.stall !== !BYPASS) begin
      errors++;
      $display("FAIL raw_wb: wb_valid=%b wb_addr=%0d stall=%b, required 1/5/%b",
               bus.wb_valid, bus.wb_addr, bus.stall, !BYPASS);
    end
    next_edge();
    checks++;
    if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b0 || bus.pending !== 8'h00) begin
      errors++;
      $display("FAIL raw_release: stall=%b wb_valid=%b pending=%b, required 0/0/0",
               bus.stall, bus.wb_valid, bus.pending);
    end
    drain();
  endtask

  // Store-type opcode writes nothing; reader of its rd must not stall.
  task automatic test_no_write();
    present(5'b10000, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0);
    #1;
    checks++;
    if (bus.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL store_decode: reg_write=%b, required 0", bus.reg_write);
    end
    next_edge();
    present(5'b00000, 3'd0, 3'd5, 1'b1, 3'd0, 1'b0);
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.pending !== 8'h00) begin
      errors++;
      $display("FAIL store_nostall: stall=%b pending=%b, required 0/0", bus.stall, bus.pending);
    end
    drain();
  endtask

  // Writes to r2 then r3; third instruction reads r4, names r3 on unused rt.
  task automatic test_back_to_back();
    present(5'b01000, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0);
    next_edge();
    present(5'b11000, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0);
    next_edge();
    present(5'b00000, 3'd0, 3'd4, 1'b1, 3'd3, 1'b0);
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.pending !== 8'b0000_1100) begin
      errors++;
      $display("FAIL b2b: stall=%b pending=%b, required 0/00001100", bus.stall, bus.pending);
    end
    bus.rt_used = 1'b1;  // now rt=3 is really read
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rt_used: stall=%b, required 1", bus.stall);
    end
    drain();
  endtask

  // Two writes to r6, then flush with a competing issue of r7.
  task automatic test_flush();
    present(5'b01001, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0);
    next_edge();
    present(5'b01001, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0);
    #1;
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.pending !== 8'b0100_0000) begin
      errors++;
      $display("FAIL flush_pre1: wb_valid=%b pending=%b, required 0/01000000", bus.wb_valid, bus.pending);
    end
    next_edge();
    present(5'b01001, 3'd7, 3'd0, 1'b0, 3'd0, 1'b0);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre2: wb_valid=%b, required 0", bus.wb_valid);
    end
    next_edge();  // flush edge
    idle_inputs();
    #1;
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 3'd6 || bus.pending !== 8'b0100_0000) begin
      errors++;
      $display("FAIL flush_retire: wb_valid=%b wb_addr=%0d pending=%b, required 1/6/01000000",
               bus.wb_valid, bus.wb_addr, bus.pending);
    end
    next_edge();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.pending !== 8'h00) begin
      errors++;
      $display("FAIL flush_after: wb_valid=%b pending=%b, required 0/0", bus.wb_valid, bus.pending);
    end
    next_edge();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.pending !== 8'h00) begin
      errors++;
      $display("FAIL flush_no_r7: wb_valid=%b pending=%b, required 0/0", bus.wb_valid, bus.pending);
    end
    drain();
  endtask

  // rd equal to rs on an empty pipeline must not stall.
  task automatic test_self_dep();
    present(5'b01000, 3'd5, 3'd5, 1'b1, 3'd5, 1'b1);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL self_dep: stall=%b, required 0", bus.stall);
    end
    drain();
  endtask

  // Fill all stages, then assert reset between edges.
  task automatic test_mid_reset();
    present(5'b01000, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0);
    next_edge();
    present(5'b01000, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0);
    next_edge();
    present(5'b01000, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0);
    next_edge();
    idle_inputs();
    #1;
    checks++;
    if (bus.pending !== 8'b0000_1110 || bus.wb_valid !== 1'b1 || bus.wb_addr !== 3'd1) begin
      errors++;
      $display("FAIL fill: pending=%b wb_valid=%b wb_addr=%0d, required 00001110/1/1",
               bus.pending, bus.wb_valid, bus.wb_addr);
    end
    #1;
    rst = 1'b1;
    present(5'b01000, 3'd0, 3'd1, 1'b1, 3'd3, 1'b1);
    #1;
    checks++;
    if (bus.pending !== 8'h00 || bus.wb_valid !== 1'b0 || bus.wb_addr !== 3'd0 ||
        bus.stall !== 1'b0 || bus.reg_write !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: pending=%b wb_valid=%b wb_addr=%0d stall=%b reg_write=%b, required 0/0/0/0/1",
               bus.pending, bus.wb_valid, bus.wb_addr, bus.stall, bus.reg_write);
    end
    next_edge();
    rst = 1'b0;
    present(5'b01000, 3'd4, 3'd3, 1'b1, 3'd1, 1'b1);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_stall: stall=%b, required 0", bus.stall);
    end
    next_edge();
    idle_inputs();
    #1;
    checks++;
    if (bus.pending !== 8'b0001_0000) begin
      errors++;
      $display("FAIL post_reset_issue: pending=%b, required 00010000", bus.pending);
    end
    drain();
  endtask

  // Full opcode sweep against a hand-built write mask (21 ones).
  task automatic test_decode_sweep();
    logic [31:0] mask;
    int          ones;
    mask = 32'hFFFE_0FC0;
    ones = 0;
    for (int op = 0; op < 32; op++) begin
      present(5'(op), 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
      #1;
      checks++;
      if (bus.reg_write !== mask[op]) begin
        errors++;
        $display("FAIL decode_%02h: reg_write=%b, required %b", op, bus.reg_write, mask[op]);
      end
      if (bus.reg_write === 1'b1) ones++;
    end
    checks++;
    if (ones != 21) begin
      errors++;
      $display("FAIL decode_count: ones=%0d, required 21", ones);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_no_write();
    test_back_to_back();
    test_flush();
    test_self_dep();
    test_mid_reset();
    test_decode_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
